// File: rtl/i2c_master_gen2.sv
// rtl/i2c_master_gen2.sv - I2C byte master: START/repeated START/WRITE/READ/STOP over a valid/ready command port
// Optional SCL clock stretching: define I2C_CLK_STRETCH_EN.
module i2c_master_gen2 #(
    parameter int QTR_CNT = 250,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = $clog2(2*QTR_CNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic              cmd_nack,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              done,
    output logic              rx_valid,
    output logic              ack_err,
    output logic              cmd_err,
    output logic              busy,
    inout  wire               scl,
    inout  wire               sda
);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(QTR_CNT - 1);
    localparam logic [CNT_W-1:0] Q_PRE  = CNT_W'(QTR_CNT - 2);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(2*QTR_CNT - 1);
    localparam logic [BIT_W-1:0] B_LAST = BIT_W'(DATA_W - 1);

    localparam logic [2:0] OP_START = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_STOP  = 3'd3;

    typedef enum logic [3:0] {
        IDLE, START_A, START_B, HOLD, RS_A, RS_B, STOP_A, STOP_B, BIT, ACK
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        qtr;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic              is_read;
    logic              nack_lat;
    logic              ack_smp;
    logic              scl_oe;
    logic              sda_oe;

    logic              sda_in;
    logic              stall;
    logic [CNT_W-1:0]  phase_last;
    logic              at_last;
    logic [DATA_W-1:0] tx_next;
    logic [DATA_W-1:0] rx_next;

    assign scl = scl_oe ? 1'b0 : 1'bz;
    assign sda = sda_oe ? 1'b0 : 1'bz;
    assign sda_in = sda;

    assign cmd_ready = (state == IDLE) || (state == HOLD);
    assign busy      = (state != IDLE);

`ifdef I2C_CLK_STRETCH_EN
    // Only quarters with SCL released can be held off by a slave pulling SCL low.
    always_comb begin
        stall = 1'b0;
        if (state == START_A || state == RS_B || state == STOP_A ||
            ((state == BIT || state == ACK) && qtr == 2'd1))
            stall = (scl == 1'b0);
    end
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        phase_last = Q_LAST;
        if (state == START_A || state == START_B || state == STOP_A || state == STOP_B)
            phase_last = H_LAST;
    end

    assign at_last = (cnt == phase_last);
    assign tx_next = tx_shift << 1;
    assign rx_next = (rx_shift << 1) | DATA_W'(sda_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            qtr      <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            is_read  <= 1'b0;
            nack_lat <= 1'b0;
            ack_smp  <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            done     <= 1'b0;
            rx_valid <= 1'b0;
            ack_err  <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            done     <= 1'b0;
            rx_valid <= 1'b0;
            ack_err  <= 1'b0;
            cmd_err  <= 1'b0;

            if (state != IDLE && state != HOLD && !stall)
                cnt <= at_last ? '0 : cnt + CNT_W'(1);

            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == OP_START) begin
                            state  <= START_A;
                            sda_oe <= 1'b1;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                START_A: begin
                    if (!stall && at_last) begin
                        state  <= START_B;
                        scl_oe <= 1'b1;
                    end
                end
                START_B: begin
                    if (at_last)
                        state <= HOLD;
                end
                // Bus parked with SCL and SDA both low so every next condition starts cleanly.
                HOLD: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_START: begin
                                state  <= RS_A;
                                sda_oe <= 1'b0;
                            end
                            OP_STOP: begin
                                state  <= STOP_A;
                                scl_oe <= 1'b0;
                            end
                            OP_WRITE, OP_READ: begin
                                state    <= BIT;
                                qtr      <= '0;
                                bit_cnt  <= '0;
                                is_read  <= (cmd_op == OP_READ);
                                nack_lat <= cmd_nack;
                                tx_shift <= tx_data;
                                sda_oe   <= (cmd_op == OP_WRITE) && !tx_data[DATA_W-1];
                            end
                            default: cmd_err <= 1'b1;
                        endcase
                    end
                end
                RS_A: begin
                    if (at_last) begin
                        state  <= RS_B;
                        scl_oe <= 1'b0;
                    end
                end
                RS_B: begin
                    if (!stall && at_last) begin
                        state  <= START_A;
                        sda_oe <= 1'b1;
                    end
                end
                STOP_A: begin
                    if (!stall && at_last) begin
                        state  <= STOP_B;
                        sda_oe <= 1'b0;
                    end
                end
                STOP_B: begin
                    if (at_last)
                        state <= IDLE;
                end
                BIT, ACK: begin
                    if (!stall) begin
                        // Result flags are registered one cycle early so they coincide with the slot's last cycle.
                        if (state == ACK && qtr == 2'd3 && cnt == Q_PRE) begin
                            done     <= 1'b1;
                            rx_valid <= is_read;
                            ack_err  <= !is_read && ack_smp;
                            if (is_read)
                                rx_data <= rx_shift;
                        end
                        if (at_last) begin
                            qtr <= qtr + 2'd1;
                            case (qtr)
                                2'd0: scl_oe <= 1'b0;
                                2'd1: begin
                                    if (state == ACK)
                                        ack_smp <= sda_in;
                                    else if (is_read)
                                        rx_shift <= rx_next;
                                end
                                2'd2: scl_oe <= 1'b1;
                                default: begin
                                    if (state == ACK) begin
                                        state  <= HOLD;
                                        sda_oe <= 1'b1;
                                    end else if (bit_cnt == B_LAST) begin
                                        state  <= ACK;
                                        sda_oe <= is_read && !nack_lat;
                                    end else begin
                                        bit_cnt  <= bit_cnt + BIT_W'(1);
                                        tx_shift <= tx_next;
                                        sda_oe   <= !is_read && !tx_next[DATA_W-1];
                                    end
                                end
                            endcase
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_gen2.sv
// tb/tb_i2c_master_gen2.sv - randomized self-checking bench for i2c_master_gen2 with an I2C slave model
// Expected timing follows I2C_CLK_STRETCH_EN when the macro is defined for the build.
module tb_i2c_master_gen2;
    localparam int Q        = 4;
    localparam int DW       = 8;
    localparam int BYTE_CYC = 4*Q*(DW+1);
    localparam int LIMIT    = 400;
`ifdef I2C_CLK_STRETCH_EN
    localparam int STRETCH_ADD = 20;
`else
    localparam int STRETCH_ADD = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic          cmd_nack;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] rx_data;
    logic          done;
    logic          rx_valid;
    logic          ack_err;
    logic          cmd_err;
    logic          busy;
    wire           scl;
    wire           sda;

    pullup (scl);
    pullup (sda);

    i2c_master_gen2 #(.QTR_CNT(Q), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_nack(cmd_nack), .tx_data(tx_data), .rx_data(rx_data),
        .done(done), .rx_valid(rx_valid), .ack_err(ack_err), .cmd_err(cmd_err),
        .busy(busy), .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    // Bus observer: bit values at SCL rising edges, START and STOP conditions.
    logic bitq[$];
    int   n_fall  = 0;
    int   n_start = 0;
    int   n_stop  = 0;
    always @(posedge scl) bitq.push_back(sda);
    always @(negedge scl) n_fall <= n_fall + 1;
    always @(negedge sda) if (scl === 1'b1) n_start <= n_start + 1;
    always @(posedge sda) if (scl === 1'b1) n_stop <= n_stop + 1;

    // Slave: drives read data after each SCL fall, ACKs writes in the ninth bit slot, can stretch SCL.
    bit            slv_arm = 1'b0;
    bit            slv_rd = 1'b0;
    bit            slv_ack = 1'b0;
    bit            slv_scl_low = 1'b0;
    logic [DW-1:0] slv_data = '0;
    int            slv_base = 0;
    int            slv_idx;
    logic          slv_sda_low;
    always_comb begin
        slv_idx = n_fall - slv_base;
        slv_sda_low = 1'b0;
        if (slv_arm) begin
            if (slv_rd)
                slv_sda_low = (slv_idx >= 0) && (slv_idx < DW) && !slv_data[DW-1-slv_idx];
            else
                slv_sda_low = slv_ack && (slv_idx == DW);
        end
    end
    assign sda = slv_sda_low ? 1'b0 : 1'bz;
    assign scl = slv_scl_low ? 1'b0 : 1'bz;

    int            n_chk = 0;
    int            n_pass = 0;
    logic [DW-1:0] m_rx = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a falling clock edge; returns just after the handshake edge.
    task automatic issue(input logic [2:0] op, input logic nack, input logic [DW-1:0] d);
        int n;
        cmd_op = op;
        cmd_nack = nack;
        tx_data = d;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_seen", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_start(input int exp_cyc);
        int k;
        int s0;
        int p0;
        s0 = n_start;
        p0 = n_stop;
        issue(3'd0, 1'b0, '0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cmd_ready && k < LIMIT);
        check("start_cycles", 32'(k - 1), 32'(exp_cyc));
        check("start_cond", 32'(n_start - s0), 32'd1);
        check("start_no_stop", 32'(n_stop - p0), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic do_stop();
        int k;
        int p0;
        p0 = n_stop;
        issue(3'd3, 1'b0, '0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < LIMIT);
        check("stop_busy_cycles", 32'(k - 1), 32'(4*Q));
        check("stop_cond", 32'(n_stop - p0), 32'd1);
        check("stop_scl_rel", 32'(scl), 32'd1);
        check("stop_sda_rel", 32'(sda), 32'd1);
    endtask

    task automatic do_byte(input bit rd, input bit nack, input logic [DW-1:0] d,
                           input bit ack, input bit stretch);
        int         k;
        int         base;
        logic [8:0] got9;
        logic [8:0] exp9;
        logic [DW-1:0] junk;
        base = bitq.size();
        slv_rd = rd;
        slv_ack = ack;
        slv_data = d;
        slv_base = n_fall;
        slv_arm = 1'b1;
        junk = DW'($urandom);
        issue(rd ? 3'd2 : 3'd1, nack, rd ? junk : d);
        if (stretch) slv_scl_low = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 25) slv_scl_low = 1'b0;
        end while (!done && k < LIMIT);
        check("byte_latency", 32'(k), 32'(BYTE_CYC + (stretch ? STRETCH_ADD : 0)));
        check("ready_low_at_done", 32'(cmd_ready), 32'd0);
        check("rx_valid", 32'(rx_valid), 32'(rd));
        check("ack_err", 32'(ack_err), 32'(!rd && !ack));
        if (rd) m_rx = d;
        check("rx_data", 32'(rx_data), 32'(m_rx));
        slv_arm = 1'b0;
        @(negedge clk);
        check("done_pulse_end", 32'({done, cmd_ready}), 32'b01);
        if (!stretch) begin
            check("bus_bit_count", 32'(bitq.size() - base), 32'd9);
            if (bitq.size() >= base + 9) begin
                for (int i = 0; i < 9; i++) got9[8-i] = bitq[base+i];
                exp9 = {d, rd ? nack : !ack};
                check("bus_bits", 32'(got9), 32'(exp9));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            r_rd;
        bit            r_nack;
        bit            r_ack;
        logic [DW-1:0] r_d;
        int            k;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_nack = 1'b0;
        tx_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({done, rx_valid, ack_err, cmd_err}), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        issue(3'd1, 1'b0, 8'h55);
        @(negedge clk);
        check("idle_cmd_err", 32'({cmd_err, busy, cmd_ready}), 32'b101);
        @(negedge clk);
        check("idle_cmd_err_end", 32'(cmd_err), 32'd0);

        do_start(4*Q);
        do_byte(1'b0, 1'b0, 8'hA6, 1'b1, 1'b0);
        do_byte(1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
        do_byte(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        do_byte(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
        do_start(6*Q);
        do_byte(1'b0, 1'b0, 8'hA7, 1'b1, 1'b0);

        for (int i = 0; i < 14; i++) begin
            r_rd   = 1'($urandom);
            r_nack = 1'($urandom);
            r_ack  = 1'($urandom);
            r_d    = DW'($urandom);
            do_byte(r_rd, r_nack, r_d, r_ack, 1'b0);
            if ($urandom_range(0, 3) == 0) do_start(6*Q);
        end

        issue(3'($urandom_range(4, 7)), 1'b0, '0);
        @(negedge clk);
        check("hold_cmd_err", 32'({cmd_err, busy, cmd_ready}), 32'b111);

        do_byte(1'b0, 1'b0, DW'($urandom), 1'b0, 1'b1);
        do_stop();

        do_start(4*Q);
        issue(3'd1, 1'b0, 8'h00);
        k = 0;
        while (k < 3*4*Q + 3) begin
            @(negedge clk);
            k++;
        end
        check("mid_byte_scl_low", 32'(scl), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_lines", 32'({scl, sda}), 32'b11);
        check("midrst_ready_busy", 32'({cmd_ready, busy}), 32'b10);
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
